i3c_bus_tx: RTL and testbench

- Controller-side bit-level transmitter that generates SCL/SDA waveforms for START, repeated START, STOP and byte writes.
- Drives the PHY's registered controller outputs: scl/sda/open-drain-vs-push-pull select.
- Samples the PHY's synchronized SDA to capture ACK/NACK.
- Sits between the controller FSM (byte/command level) and the I3C PHY.

---
 rtl/i3c_bus_tx.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_i3c_bus_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i3c_bus_tx.sv
// I3C controller bit-level transmitter.
// Turns byte/command requests (START, STOP, WRITE_BYTE) into registered
// SCL/SDA drive values plus an open-drain/push-pull select for the PHY,
// and samples the synchronized SDA during the ACK slot.
module i3c_bus_tx #(
    parameter int CntW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [1:0]      cmd_i,
    input  logic [7:0]      data_i,
    input  logic            ack_mode_i,
    input  logic            pp_i,
    input  logic [CntW-1:0] t_low_i,
    input  logic [CntW-1:0] t_high_i,
    input  logic            sda_i,
    output logic            scl_o,
    output logic            sda_o,
    output logic            sel_od_pp_o,
    output logic            done_o,
    output logic            ack_o,
    output logic            err_o
);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,    // bus free, SCL high
        ST_HOLD,    // SCL held low by this controller
        ST_S_HI,    // START from idle: SDA low while SCL high
        ST_SR_LO,   // repeated START: SDA released while SCL low
        ST_SR_HI1,  // repeated START: SCL high, SDA high (setup)
        ST_SR_HI2,  // repeated START: SDA low while SCL high (hold)
        ST_P_LO,    // STOP: SDA low while SCL low
        ST_P_HI,    // STOP: SCL high, SDA still low (setup)
        ST_W_LO,    // byte write: SCL low half of a bit slot
        ST_W_HI     // byte write: SCL high half of a bit slot
    } state_t;

    // FSM and phase bookkeeping
    state_t          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [3:0]      r_bit, w_bit_next;

    // Command parameters captured at accept
    logic [7:0]      r_data;
    logic            r_ack_mode;
    logic            r_pp;
    logic [CntW-1:0] r_tl_m1;
    logic [CntW-1:0] r_th_m1;

    // Registered outputs
    logic r_scl, w_scl_next;
    logic r_sda, w_sda_next;
    logic r_sel, w_sel_next;
    logic r_done, w_done_next;
    logic r_ack, w_ack_next;
    logic r_err, w_err_next;

    logic            w_accept;
    logic            w_last;
    logic [CntW-1:0] w_tl_in_m1;
    logic [CntW-1:0] w_th_in_m1;
    logic [3:0]      w_bit_inc;

    // Value driven on SDA in bit slot idx (0..7 data MSB first, 8 = ninth bit)
    function automatic logic slot_sda(input logic [3:0] idx, input logic [7:0] d,
                                      input logic am);
        if (idx == 4'd8)
            return am ? 1'b1 : ~(^d);
        else
            return d[3'd7 - idx[2:0]];
    endfunction

    assign cmd_ready_o = (r_state == ST_IDLE) || (r_state == ST_HOLD);
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_last      = (r_cnt == '0);
    assign w_bit_inc   = r_bit + 4'd1;
    // A zero timing value is treated as one cycle, so the reload value is 0
    assign w_tl_in_m1  = (t_low_i  == '0) ? '0 : t_low_i  - CntW'(1);
    assign w_th_in_m1  = (t_high_i == '0) ? '0 : t_high_i - CntW'(1);

    assign scl_o       = r_scl;
    assign sda_o       = r_sda;
    assign sel_od_pp_o = r_sel;
    assign done_o      = r_done;
    assign ack_o       = r_ack;
    assign err_o       = r_err;

    // State, phase counter and bus output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_sel   <= 1'b0;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_scl   <= w_scl_next;
            r_sda   <= w_sda_next;
            r_sel   <= w_sel_next;
            r_done  <= w_done_next;
            r_ack   <= w_ack_next;
            r_err   <= w_err_next;
        end
    end

    // Capture command parameters so later input changes cannot disturb a transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data     <= '0;
            r_ack_mode <= 1'b0;
            r_pp       <= 1'b0;
            r_tl_m1    <= '0;
            r_th_m1    <= '0;
        end else if (w_accept) begin
            r_data     <= data_i;
            r_ack_mode <= ack_mode_i;
            r_pp       <= pp_i;
            r_tl_m1    <= w_tl_in_m1;
            r_th_m1    <= w_th_in_m1;
        end
    end

    // Next-state and next-output logic; outputs hold unless a phase boundary changes them
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_scl_next   = r_scl;
        w_sda_next   = r_sda;
        w_sel_next   = r_sel;
        w_done_next  = 1'b0;
        w_ack_next   = r_ack;
        w_err_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_i)
                        CMD_START: begin
                            w_state_next = ST_S_HI;
                            w_cnt_next   = w_th_in_m1;
                            w_scl_next   = 1'b1;
                            w_sda_next   = 1'b0;
                            w_sel_next   = 1'b0;
                        end
                        CMD_STOP: begin
                            // bus already free: acknowledge without activity
                            w_done_next = 1'b1;
                        end
                        default: begin
                            // a byte write needs SCL held low first
                            w_done_next = 1'b1;
                            w_err_next  = 1'b1;
                        end
                    endcase
                end
            end

            ST_HOLD: begin
                if (cmd_valid_i) begin
                    case (cmd_i)
                        CMD_START: begin
                            w_state_next = ST_SR_LO;
                            w_cnt_next   = w_tl_in_m1;
                            w_scl_next   = 1'b0;
                            w_sda_next   = 1'b1;
                            w_sel_next   = 1'b0;
                        end
                        CMD_STOP: begin
                            w_state_next = ST_P_LO;
                            w_cnt_next   = w_tl_in_m1;
                            w_scl_next   = 1'b0;
                            w_sda_next   = 1'b0;
                            w_sel_next   = 1'b0;
                        end
                        CMD_WRITE: begin
                            w_state_next = ST_W_LO;
                            w_cnt_next   = w_tl_in_m1;
                            w_bit_next   = 4'd0;
                            w_scl_next   = 1'b0;
                            w_sda_next   = slot_sda(4'd0, data_i, ack_mode_i);
                            w_sel_next   = pp_i;
                            w_ack_next   = 1'b0;
                        end
                        default: begin
                            w_done_next = 1'b1;
                            w_err_next  = 1'b1;
                        end
                    endcase
                end
            end

            ST_S_HI: begin
                if (w_last) begin
                    w_state_next = ST_HOLD;
                    w_scl_next   = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            ST_SR_LO: begin
                if (w_last) begin
                    w_state_next = ST_SR_HI1;
                    w_cnt_next   = r_th_m1;
                    w_scl_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            ST_SR_HI1: begin
                if (w_last) begin
                    w_state_next = ST_SR_HI2;
                    w_cnt_next   = r_th_m1;
                    w_sda_next   = 1'b0;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            ST_SR_HI2: begin
                if (w_last) begin
                    w_state_next = ST_HOLD;
                    w_scl_next   = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            ST_P_LO: begin
                if (w_last) begin
                    w_state_next = ST_P_HI;
                    w_cnt_next   = r_th_m1;
                    w_scl_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            ST_P_HI: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                    w_sda_next   = 1'b1;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            ST_W_LO: begin
                if (w_last) begin
                    w_state_next = ST_W_HI;
                    w_cnt_next   = r_th_m1;
                    w_scl_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            ST_W_HI: begin
                if (w_last) begin
                    if (r_bit == 4'd8) begin
                        // end of ninth slot: pull SCL low, keep SDA where it is
                        w_state_next = ST_HOLD;
                        w_scl_next   = 1'b0;
                        w_done_next  = 1'b1;
                        if (r_ack_mode)
                            w_ack_next = ~sda_i;
                    end else begin
                        // SDA only moves on the first low cycle of a slot
                        w_state_next = ST_W_LO;
                        w_cnt_next   = r_tl_m1;
                        w_bit_next   = w_bit_inc;
                        w_scl_next   = 1'b0;
                        w_sda_next   = slot_sda(w_bit_inc, r_data, r_ack_mode);
                        w_sel_next   = ((w_bit_inc == 4'd8) && r_ack_mode) ? 1'b0 : r_pp;
                    end
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_scl_next   = 1'b1;
                w_sda_next   = 1'b1;
                w_sel_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i3c_bus_tx.sv
// Directed testbench for i3c_bus_tx: walks the command sequences cycle by
// cycle and compares bus outputs against hand-computed waveforms.
module tb_i3c_bus_tx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_i = 2'd0;
    logic [7:0] data_i = 8'h00;
    logic       ack_mode_i = 1'b0;
    logic       pp_i = 1'b0;
    logic [7:0] t_low_i = 8'd1;
    logic [7:0] t_high_i = 8'd1;
    logic       sda_i = 1'b1;
    logic       scl_o, sda_o, sel_od_pp_o, done_o, ack_o, err_o;

    int n_checks = 0;
    int n_errors = 0;

    i3c_bus_tx #(.CntW(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_i       (cmd_i),
        .data_i      (data_i),
        .ack_mode_i  (ack_mode_i),
        .pp_i        (pp_i),
        .t_low_i     (t_low_i),
        .t_high_i    (t_high_i),
        .sda_i       (sda_i),
        .scl_o       (scl_o),
        .sda_o       (sda_o),
        .sel_od_pp_o (sel_od_pp_o),
        .done_o      (done_o),
        .ack_o       (ack_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare the bus outputs sampled in the current cycle
    task automatic bus(input string tag, input logic scl, input logic sda,
                       input logic sel, input logic done);
        chk({tag, ".scl"}, scl_o, scl);
        chk({tag, ".sda"}, sda_o, sda);
        chk({tag, ".sel"}, sel_od_pp_o, sel);
        chk({tag, ".done"}, done_o, done);
    endtask

    // Present a command at a negedge, hold it over one rising edge (cycle k),
    // then scramble the inputs to show they are not used after accept.
    task automatic issue(input logic [1:0] cmd, input logic [7:0] d, input logic am,
                         input logic pp, input logic [7:0] tl, input logic [7:0] th);
        @(negedge clk_i);
        chk("ready_at_issue", cmd_ready_o, 1'b1);
        cmd_i       = cmd;
        data_i      = d;
        ack_mode_i  = am;
        pp_i        = pp;
        t_low_i     = tl;
        t_high_i    = th;
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        data_i      = ~d;
        ack_mode_i  = ~am;
        pp_i        = ~pp;
        t_low_i     = 8'd9;
        t_high_i    = 8'd7;
        $display("issue cmd=%0d data=%02h ack_mode=%0b pp=%0b tl=%0d th=%0d", cmd, d, am, pp, tl, th);
    endtask

    initial begin
        logic [8:0] pat;
        logic [7:0] d7e;

        // Reset state
        @(negedge clk_i);
        bus("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset.ack", ack_o, 1'b0);
        chk("reset.err", err_o, 1'b0);
        chk("reset.ready", cmd_ready_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // STOP from IDLE: done only, no error
        issue(2'd1, 8'h00, 1'b0, 1'b0, 8'd2, 8'd2);
        @(negedge clk_i);
        bus("idle_stop", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("idle_stop.err", err_o, 1'b0);

        // WRITE from IDLE and reserved command: done + error, bus untouched
        issue(2'd2, 8'hFF, 1'b0, 1'b1, 8'd2, 8'd2);
        @(negedge clk_i);
        bus("idle_write", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("idle_write.err", err_o, 1'b1);
        issue(2'd3, 8'h00, 1'b0, 1'b0, 8'd2, 8'd2);
        @(negedge clk_i);
        bus("idle_rsvd", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("idle_rsvd.err", err_o, 1'b1);
        @(negedge clk_i);
        chk("idle_rsvd.err_pulse", err_o, 1'b0);

        // START from IDLE, t_high=3
        issue(2'd0, 8'h00, 1'b0, 1'b0, 8'd4, 8'd3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            bus($sformatf("start_c%0d", c + 1), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk_i);
        bus("start_done", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("start_done.ready", cmd_ready_o, 1'b1);

        // WRITE 0xA5, T-bit, push-pull, tl=4 th=3 -> done at k+64
        pat = {8'hA5, 1'b1};
        issue(2'd2, 8'hA5, 1'b0, 1'b1, 8'd4, 8'd3);
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < 7; c++) begin
                @(negedge clk_i);
                bus($sformatf("wA5_s%0d_c%0d", s, c), (c < 4) ? 1'b0 : 1'b1,
                    pat[8 - s], 1'b1, 1'b0);
            end
        end
        @(negedge clk_i);
        bus("wA5_done", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("wA5_done.ack", ack_o, 1'b0);
        chk("wA5_done.err", err_o, 1'b0);

        // WRITE 0x7E with ACK slot, target ACKs then NACKs
        d7e = 8'h7E;
        for (int rep = 0; rep < 2; rep++) begin
            sda_i = (rep == 0) ? 1'b0 : 1'b1;
            issue(2'd2, d7e, 1'b1, 1'b1, 8'd2, 8'd2);
            for (int s = 0; s < 9; s++) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk_i);
                    bus($sformatf("w7E_r%0d_s%0d_c%0d", rep, s, c), (c < 2) ? 1'b0 : 1'b1,
                        (s < 8) ? d7e[7 - s] : 1'b1, (s < 8) ? 1'b1 : 1'b0, 1'b0);
                end
            end
            @(negedge clk_i);
            chk($sformatf("w7E_r%0d.done", rep), done_o, 1'b1);
            chk($sformatf("w7E_r%0d.scl", rep), scl_o, 1'b0);
            chk($sformatf("w7E_r%0d.ack", rep), ack_o, (rep == 0) ? 1'b1 : 1'b0);
            @(negedge clk_i);
            chk($sformatf("w7E_r%0d.ack_hold", rep), ack_o, (rep == 0) ? 1'b1 : 1'b0);
        end
        sda_i = 1'b1;

        // Repeated START, tl=2 th=2
        issue(2'd0, 8'h00, 1'b0, 1'b1, 8'd2, 8'd2);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            bus($sformatf("sr_c%0d", c + 1), (c < 2) ? 1'b0 : 1'b1,
                (c < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk_i);
        bus("sr_done", 1'b0, 1'b0, 1'b0, 1'b1);

        // STOP from HOLD, tl=2 th=2
        issue(2'd1, 8'h00, 1'b0, 1'b1, 8'd2, 8'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            bus($sformatf("stop_c%0d", c + 1), (c < 2) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk_i);
        bus("stop_done", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("stop_done.ready", cmd_ready_o, 1'b1);

        // START from IDLE with t_high=0 behaves as one cycle
        issue(2'd0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk_i);
        bus("start0_c1", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        bus("start0_done", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in slot 4 of a write: bus released immediately
        issue(2'd2, 8'h00, 1'b0, 1'b1, 8'd2, 8'd2);
        for (int c = 0; c < 13; c++) @(negedge clk_i);
        bus("pre_rst_slot4", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst.ready", cmd_ready_o, 1'b0);
        #1;
        rst_i = 1'b1;
        #1;
        bus("in_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("post_rst.ready", cmd_ready_o, 1'b1);
        chk("post_rst.ack", ack_o, 1'b0);
        // STOP completing at k+1 shows the block is back in IDLE
        issue(2'd1, 8'h00, 1'b0, 1'b0, 8'd2, 8'd2);
        @(negedge clk_i);
        bus("post_rst_stop", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("post_rst_stop.err", err_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
